pipe_skid_buffer: RTL and testbench

- Parametrised pipeline-stage register between datapath stages; the successor to the plain enable-gated stage register.
- Replaces the bare enable with a valid/ready handshake and a two-entry skid buffer.
- Supports full throughput, registered backpressure with no combinational ready path, and synchronous flush for branch/exception squash.
- Preserves order; one cycle of latency.

---
 rtl/pipe_skid_buffer.sv | 94 +++++++++
 tb/tb_pipe_skid_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Handshake outputs are decoded only from the state register, so ready never depends combinationally on out_ready.
module pipe_skid_buffer #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // State encodings double as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_next;
  logic [WIDTH-1:0] w_skid_next;
  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid  = (r_state != EMPTY);
  assign in_ready   = (r_state != FULL);
  assign count      = r_state;
  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
    end else begin
      r_state <= w_state_next;
      r_main  <= w_main_next;
      r_skid  <= w_skid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      // Squash overrides any handshake happening on the same edge.
      w_state_next = EMPTY;
      w_main_next  = RST_VAL;
      w_skid_next  = RST_VAL;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_next = ONE;
            w_main_next  = in_data;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_next = in_data;
          end else if (w_in_fire) begin
            w_state_next = FULL;
            w_skid_next  = in_data;
          end else if (w_out_fire) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_next = ONE;
            w_main_next  = r_skid;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed self-checking bench for pipe_skid_buffer; inputs change and outputs are checked on the falling edge.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  count;

  int checks;
  int errors;

  pipe_skid_buffer #(.WIDTH(32), .RST_VAL(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [31:0] od,
                           input logic ir, input logic [1:0] cnt);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_data"}, out_data, od);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    chk({tag, ".count"}, {30'd0, count}, {30'd0, cnt});
    $display("step %-12s out_valid=%0b out_data=%h in_ready=%0b count=%0d",
             tag, out_valid, out_data, in_ready, count);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    // Asynchronous reset before any clock edge; inputs active but ignored.
    #3;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1;
    chk_state("rst_async", 1'b0, 32'h0, 1'b1, 2'd0);
    step();
    chk_state("rst_hold", 1'b0, 32'h0, 1'b1, 2'd0);

    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA5A5_A5A5;
    out_ready = 1'b0;
    step();
    chk_state("rst_first", 1'b1, 32'hA5A5_A5A5, 1'b1, 2'd1);

    // Drain: main is not re-zeroed.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_state("drain", 1'b0, 32'hA5A5_A5A5, 1'b1, 2'd0);

    // Streaming at full throughput.
    for (int i = 1; i <= 16; i++) begin
      in_valid  = 1'b1;
      in_data   = i;
      out_ready = 1'b1;
      step();
      chk_state($sformatf("stream%0d", i), 1'b1, i, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    step();
    chk_state("stream_end", 1'b0, 32'd16, 1'b1, 2'd0);

    // Backpressure.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    chk_state("bp_push1", 1'b1, 32'h11, 1'b1, 2'd1);
    in_data = 32'h22;
    step();
    chk_state("bp_push2", 1'b1, 32'h11, 1'b0, 2'd2);
    in_data = 32'h33;
    step();
    chk_state("bp_stall1", 1'b1, 32'h11, 1'b0, 2'd2);
    step();
    chk_state("bp_stall2", 1'b1, 32'h11, 1'b0, 2'd2);
    out_ready = 1'b1;
    step();
    chk_state("bp_out22", 1'b1, 32'h22, 1'b1, 2'd1);
    step();
    chk_state("bp_out33", 1'b1, 32'h33, 1'b1, 2'd1);
    in_valid = 1'b0;
    step();
    chk_state("bp_empty", 1'b0, 32'h33, 1'b1, 2'd0);

    // Simultaneous in_fire and out_fire while holding one entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    chk_state("sim_load5", 1'b1, 32'h5, 1'b1, 2'd1);
    in_data   = 32'h6;
    out_ready = 1'b1;
    step();
    chk_state("sim_both", 1'b1, 32'h6, 1'b1, 2'd1);
    in_valid = 1'b0;
    step();
    chk_state("sim_empty", 1'b0, 32'h6, 1'b1, 2'd0);

    // Flush from FULL with concurrent in/out handshakes.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    step();
    in_data = 32'hBB;
    step();
    chk_state("fl_full", 1'b1, 32'hAA, 1'b0, 2'd2);
    in_data   = 32'hCC;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    chk_state("fl_flushed", 1'b0, 32'h0, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    chk_state("fl_nocap", 1'b0, 32'h0, 1'b1, 2'd0);

    // Asynchronous reset pulse between edges while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h12;
    step();
    in_data = 32'h34;
    step();
    chk_state("ar_full", 1'b1, 32'h12, 1'b0, 2'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_state("ar_async", 1'b0, 32'h0, 1'b1, 2'd0);
    #1;
    rst = 1'b0;
    step();
    chk_state("ar_after", 1'b0, 32'h0, 1'b1, 2'd0);
    in_valid = 1'b1;
    in_data  = 32'h77;
    step();
    chk_state("ar_push77", 1'b1, 32'h77, 1'b1, 2'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_state("ar_alone", 1'b0, 32'h77, 1'b1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
